dcache_hit_profiler: RTL and testbench

//  Consumes the data-memory access stream (address + read/write strobes at the DM port) and models a

---
 rtl/dcache_hit_profiler_if.sv | 30 +++
 rtl/dcache_hit_profiler.sv | 142 ++++++++++++++
 tb/tb_dcache_hit_profiler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_hit_profiler_if.sv
// Access-tap bus between the DM port and the hit profiler.
// The master drives strobes, address and control pulses; the profiler answers with verdicts and counters.
interface dcache_hit_profiler_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              acc_rd;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic              flush;
  logic              clr;
  logic              ready;
  logic              res_valid;
  logic              hit;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              sat;

  modport master (
    output acc_rd, acc_wr, acc_addr, flush, clr,
    input  ready, res_valid, hit, acc_cnt, hit_cnt, miss_cnt, drop_cnt, sat
  );

  modport slave (
    input  acc_rd, acc_wr, acc_addr, flush, clr,
    output ready, res_valid, hit, acc_cnt, hit_cnt, miss_cnt, drop_cnt, sat
  );
endinterface

// File: rtl/dcache_hit_profiler.sv
// Direct-mapped, allocate-on-miss cache model that watches the data-memory access stream
// and keeps per-access hit/miss verdicts plus saturating statistics counters.
module dcache_hit_profiler #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 6,
  parameter int CNT_W    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  dcache_hit_profiler_if.slave  bus
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_LINE = INDEX_W'(LINES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [INDEX_W-1:0] ptr;
  logic               ready;

  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q [LINES];

  logic               access, accept, drop, lookup_hit;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               unused_offset;

  logic               res_valid_q, hit_q, sat_q;
  logic [CNT_W-1:0]   acc_q, hit_cnt_q, miss_q, drop_q;
  logic [CNT_W-1:0]   acc_nxt, hit_nxt, miss_nxt, drop_nxt;
  logic               sat_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign access        = bus.acc_rd | bus.acc_wr;
  assign accept        = access & ready;
  assign drop          = access & ~ready;
  assign index         = bus.acc_addr[OFFSET_W +: INDEX_W];
  assign tag           = bus.acc_addr[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^bus.acc_addr[OFFSET_W-1:0];
  assign lookup_hit    = valid_q[index] && (tag_q[index] == tag);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // A flush request is only honoured from IDLE; the sweep ends after the last line is cleared.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.flush) state_nxt = FLUSH;
      FLUSH:   if (ptr == LAST_LINE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:    ready = 1'b1;
      FLUSH:   ready = 1'b0;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)              ptr <= '0;
    else if (state == FLUSH) ptr <= ptr + INDEX_W'(1);
    else                     ptr <= '0;
  end

  // Fills never collide with the sweep: accesses are only accepted while IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                     valid_q <= '0;
    else if (state == FLUSH)        valid_q[ptr] <= 1'b0;
    else if (accept && !lookup_hit) valid_q[index] <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (accept && !lookup_hit) tag_q[index] <= tag;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      res_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      res_valid_q <= accept;
      hit_q       <= accept & lookup_hit;
    end
  end

  always_comb begin
    acc_nxt  = accept ? sat_inc(acc_q) : acc_q;
    hit_nxt  = (accept && lookup_hit) ? sat_inc(hit_cnt_q) : hit_cnt_q;
    miss_nxt = (accept && !lookup_hit) ? sat_inc(miss_q) : miss_q;
    drop_nxt = drop ? sat_inc(drop_q) : drop_q;
    sat_hit  = (acc_nxt == CNT_MAX) || (hit_nxt == CNT_MAX) ||
               (miss_nxt == CNT_MAX) || (drop_nxt == CNT_MAX);
  end

  // A clear wins over any same-cycle increment, so that access is simply not counted.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q     <= '0;
      hit_cnt_q <= '0;
      miss_q    <= '0;
      drop_q    <= '0;
      sat_q     <= 1'b0;
    end else if (bus.clr) begin
      acc_q     <= '0;
      hit_cnt_q <= '0;
      miss_q    <= '0;
      drop_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      acc_q     <= acc_nxt;
      hit_cnt_q <= hit_nxt;
      miss_q    <= miss_nxt;
      drop_q    <= drop_nxt;
      sat_q     <= sat_q | sat_hit;
    end
  end

  assign bus.ready     = ready;
  assign bus.res_valid = res_valid_q;
  assign bus.hit       = hit_q;
  assign bus.acc_cnt   = acc_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_dcache_hit_profiler.sv
// Scoreboard bench: two profilers (32-bit and 4-bit counters) share one stimulus stream and
// are compared against a cache model built from plain arrays and unbounded counts.
module tb_dcache_hit_profiler;

  logic clk;
  logic rst_n;

  dcache_hit_profiler_if #(.ADDR_W(32), .CNT_W(32)) bus_a ();
  dcache_hit_profiler_if #(.ADDR_W(32), .CNT_W(4))  bus_b ();

  dcache_hit_profiler #(.ADDR_W(32), .OFFSET_W(4), .INDEX_W(6), .CNT_W(32)) dut_a (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_a)
  );

  dcache_hit_profiler #(.ADDR_W(32), .OFFSET_W(4), .INDEX_W(6), .CNT_W(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int edge_n;
    bit hit;
  } verdict_t;

  localparam longint MAX_A = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX_B = 15;

  verdict_t    exp_q[$];
  bit          mvalid [64];
  logic [21:0] mtag   [64];
  int          flush_left;
  longint      n_acc, n_hit, n_miss, n_drop;
  bit          sat_a, sat_b;

  int total = 0;
  int bad   = 0;
  int edge_no = 0;
  int low_cnt = 0;
  bit mon_en  = 0;

  function automatic longint clip(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    flush_left = 0;
    n_acc = 0; n_hit = 0; n_miss = 0; n_drop = 0;
    sat_a = 0; sat_b = 0;
    exp_q.delete();
  endfunction

  // One clock edge of the cache as described: lookup/fill when idle, sweep one line when flushing.
  function automatic void modelStep(input bit rd, input bit wr, input logic [31:0] addr,
                                    input bit flush, input bit clr);
    bit access = rd | wr;
    int idx = int'(addr[9:4]);
    logic [21:0] tg = addr[31:10];
    bit h;
    verdict_t v;
    if (flush_left == 0) begin
      if (access) begin
        h = mvalid[idx] && (mtag[idx] == tg);
        v.edge_n = edge_no + 1;
        v.hit = h;
        exp_q.push_back(v);
        if (!h) begin
          mvalid[idx] = 1'b1;
          mtag[idx] = tg;
        end
        n_acc++;
        if (h) n_hit++; else n_miss++;
      end
      if (flush) flush_left = 64;
    end else begin
      mvalid[64 - flush_left] = 1'b0;
      flush_left--;
      if (access) n_drop++;
    end
    if (clr) begin
      n_acc = 0; n_hit = 0; n_miss = 0; n_drop = 0;
      sat_a = 0; sat_b = 0;
    end else begin
      sat_a = sat_a | (n_acc >= MAX_A) | (n_hit >= MAX_A) | (n_miss >= MAX_A) | (n_drop >= MAX_A);
      sat_b = sat_b | (n_acc >= MAX_B) | (n_hit >= MAX_B) | (n_miss >= MAX_B) | (n_drop >= MAX_B);
    end
  endfunction

  task automatic driveBoth(input bit rd, input bit wr, input logic [31:0] addr,
                           input bit flush, input bit clr);
    bus_a.acc_rd = rd; bus_a.acc_wr = wr; bus_a.acc_addr = addr; bus_a.flush = flush; bus_a.clr = clr;
    bus_b.acc_rd = rd; bus_b.acc_wr = wr; bus_b.acc_addr = addr; bus_b.flush = flush; bus_b.clr = clr;
  endtask

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input bit flush, input bit clr);
    @(negedge clk);
    driveBoth(rd, wr, addr, flush, clr);
    modelStep(rd, wr, addr, flush, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'h0, 0, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"},     bus_a.ready, 1);
    checkOutput({tag, "_res_valid"}, bus_a.res_valid, 0);
    checkOutput({tag, "_hit"},       bus_a.hit, 0);
    checkOutput({tag, "_acc"},       bus_a.acc_cnt, 0);
    checkOutput({tag, "_miss"},      bus_a.miss_cnt, 0);
    checkOutput({tag, "_drop"},      bus_a.drop_cnt, 0);
    checkOutput({tag, "_sat_b"},     bus_b.sat, 0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    driveBoth(0, 0, 32'h0, 0, 0);
    modelReset();
    #1;
    checkResetValues(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: verdicts are paired with the scoreboard by edge number; counters follow the model.
  always @(posedge clk) begin
    edge_no++;
    #1;
    if (!bus_a.ready) low_cnt++;
    if (mon_en && rst_n) begin
      automatic bit exp_rv = (exp_q.size() > 0) && (exp_q[0].edge_n == edge_no);
      checkOutput("res_valid_a", bus_a.res_valid, exp_rv);
      checkOutput("res_valid_b", bus_b.res_valid, exp_rv);
      if (exp_rv) begin
        automatic verdict_t v = exp_q.pop_front();
        checkOutput("hit_a", bus_a.hit, v.hit);
        checkOutput("hit_b", bus_b.hit, v.hit);
      end
      checkOutput("ready_a",  bus_a.ready, flush_left == 0);
      checkOutput("ready_b",  bus_b.ready, flush_left == 0);
      checkOutput("acc_a",    bus_a.acc_cnt,  clip(n_acc, MAX_A));
      checkOutput("hitcnt_a", bus_a.hit_cnt,  clip(n_hit, MAX_A));
      checkOutput("miss_a",   bus_a.miss_cnt, clip(n_miss, MAX_A));
      checkOutput("drop_a",   bus_a.drop_cnt, clip(n_drop, MAX_A));
      checkOutput("sat_a",    bus_a.sat, sat_a);
      checkOutput("acc_b",    bus_b.acc_cnt,  clip(n_acc, MAX_B));
      checkOutput("hitcnt_b", bus_b.hit_cnt,  clip(n_hit, MAX_B));
      checkOutput("miss_b",   bus_b.miss_cnt, clip(n_miss, MAX_B));
      checkOutput("drop_b",   bus_b.drop_cnt, clip(n_drop, MAX_B));
      checkOutput("sat_b",    bus_b.sat, sat_b);
    end
  end

  initial begin
    logic [31:0] addr;
    rst_n = 1'b0;
    driveBoth(0, 0, 32'h0, 0, 0);
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkResetValues("por");
    rst_n = 1'b1;
    mon_en = 1'b1;

    $display("[TB] read miss then same-block hit");
    applyStimulus(1, 0, 32'h0000_0100, 0, 0);
    applyStimulus(1, 0, 32'h0000_0104, 0, 0);
    settle();
    checkOutput("t1_acc",  bus_a.acc_cnt, 2);
    checkOutput("t1_hit",  bus_a.hit_cnt, 1);
    checkOutput("t1_miss", bus_a.miss_cnt, 1);

    $display("[TB] conflict misses on index 16");
    doReset("t2rst");
    applyStimulus(0, 1, 32'h0000_0100, 0, 0);
    applyStimulus(1, 0, 32'h0000_0500, 0, 0);
    applyStimulus(1, 0, 32'h0000_0100, 0, 0);
    settle();
    checkOutput("t2_miss", bus_a.miss_cnt, 3);
    checkOutput("t2_hit",  bus_a.hit_cnt, 0);

    $display("[TB] flush sweep with dropped reads");
    doReset("t3rst");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 32'(i * 16), 0, 0);
    low_cnt = 0;
    applyStimulus(0, 0, 32'h0, 1, 0);
    for (int j = 0; j < 70; j++) begin
      if (j == 0 || j == 10 || j == 30 || j == 50 || j == 63) applyStimulus(1, 0, 32'h20, 0, 0);
      else applyStimulus(0, 0, 32'h0, 0, 0);
    end
    settle();
    checkOutput("t3_flush_len", low_cnt, 64);
    checkOutput("t3_drop", bus_a.drop_cnt, 5);
    applyStimulus(1, 0, 32'h0000_0000, 0, 0);
    settle();
    checkOutput("t3_refill_miss", bus_a.miss_cnt, 5);

    $display("[TB] flush with same-cycle hit, repeated flush ignored");
    doReset("t4rst");
    applyStimulus(1, 0, 32'h0000_0200, 0, 0);
    low_cnt = 0;
    applyStimulus(1, 0, 32'h0000_0208, 1, 0);
    settle();
    checkOutput("t4_rv",  bus_a.res_valid, 1);
    checkOutput("t4_hit", bus_a.hit, 1);
    for (int j = 0; j < 70; j++) applyStimulus(0, 0, 32'h0, j == 20, 0);
    settle();
    checkOutput("t4_flush_len", low_cnt, 64);

    $display("[TB] counter saturation and clear");
    doReset("t5rst");
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 32'h0000_0300, 0, 0);
    settle();
    checkOutput("t5_acc_b",  bus_b.acc_cnt, 15);
    checkOutput("t5_hit_b",  bus_b.hit_cnt, 15);
    checkOutput("t5_miss_b", bus_b.miss_cnt, 1);
    checkOutput("t5_sat_b",  bus_b.sat, 1);
    checkOutput("t5_hit_a",  bus_a.hit_cnt, 19);
    applyStimulus(1, 0, 32'h0000_0300, 0, 1);
    settle();
    checkOutput("t5_clr_acc_b", bus_b.acc_cnt, 0);
    checkOutput("t5_clr_hit_b", bus_b.hit_cnt, 0);
    checkOutput("t5_clr_sat_b", bus_b.sat, 0);

    $display("[TB] reset in the middle of a flush");
    doReset("t6rst");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 32'(i * 16 + 32'h400), 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 0);
    idle(10);
    doReset("t6mid");
    applyStimulus(1, 0, 32'h0000_0430, 0, 0);
    settle();
    checkOutput("t6_miss", bus_a.miss_cnt, 1);

    $display("[TB] randomized traffic");
    doReset("rnd");
    for (int i = 0; i < 1500; i++) begin
      automatic int r = int'($urandom_range(0, 99));
      addr = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 4'($urandom)};
      if (($urandom_range(0, 3) == 0)) addr[9:4] = 6'($urandom_range(0, 3));
      applyStimulus(r < 45, (r >= 40) && (r < 70), addr,
                    $urandom_range(0, 149) == 0, $urandom_range(0, 249) == 0);
    end
    idle(70);
    settle();
    checkOutput("leftover_verdicts", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
